// File: rtl/alu_trace_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : alu_trace_pkg
//  Purpose : Shared types and constants for the ALU trace sequencer: record
//            layout, stream field tags, emit FSM states, field selector.
//  Rev     : 1.0  initial release
// ============================================================================
package alu_trace_pkg;

    // Stream field tags, in emission order
    localparam logic [2:0] TAG_OPCODE = 3'd0;
    localparam logic [2:0] TAG_A      = 3'd1;
    localparam logic [2:0] TAG_B      = 3'd2;
    localparam logic [2:0] TAG_RESULT = 3'd3;
    localparam logic [2:0] TAG_CARRY  = 3'd4;
    localparam logic [2:0] TAG_BORROW = 3'd5;
    localparam logic [2:0] TAG_PC     = 3'd6;

    typedef struct packed {
        logic [7:0] opcode;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] result;
        logic       carry;
        logic       borrow;
        logic [7:0] pc;
    } trace_rec_t;

    localparam int REC_W = $bits(trace_rec_t);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2
    } emit_state_t;

    // Byte presented on the stream for a given tag; flags are zero-extended
    function automatic logic [7:0] rec_field(input trace_rec_t rec, input logic [2:0] tag);
        logic [7:0] v;
        v = 8'h00;
        case (tag)
            TAG_OPCODE: v = rec.opcode;
            TAG_A:      v = rec.a;
            TAG_B:      v = rec.b;
            TAG_RESULT: v = rec.result;
            TAG_CARRY:  v = {7'b0, rec.carry};
            TAG_BORROW: v = {7'b0, rec.borrow};
            TAG_PC:     v = rec.pc;
            default:    v = 8'h00;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_trace_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module  : alu_trace_sequencer_if
//  Purpose : CPU record capture bus plus the outgoing tagged byte stream.
//            slave = the sequencer, master = record source / stream sink.
//  Rev     : 1.0  initial release
// ============================================================================
interface alu_trace_sequencer_if;
    logic       rec_valid;
    logic [7:0] rec_opcode;
    logic [7:0] rec_a;
    logic [7:0] rec_b;
    logic [7:0] rec_result;
    logic       rec_carry;
    logic       rec_borrow;
    logic [7:0] rec_pc;

    logic [7:0] out_data;
    logic [2:0] out_type;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;

    modport slave (
        input  rec_valid, rec_opcode, rec_a, rec_b, rec_result, rec_carry, rec_borrow, rec_pc,
        input  out_ready,
        output out_data, out_type, out_valid, out_last
    );

    modport master (
        output rec_valid, rec_opcode, rec_a, rec_b, rec_result, rec_carry, rec_borrow, rec_pc,
        output out_ready,
        input  out_data, out_type, out_valid, out_last
    );
endinterface
`default_nettype wire

// File: rtl/trace_record_fifo.sv
`default_nettype none
// ============================================================================
//  Module  : trace_record_fifo
//  Purpose : Show-ahead synchronous FIFO for captured trace records. A push
//            is accepted when full only if a pop happens on the same edge.
//  Rev     : 1.0  initial release
// ============================================================================
module trace_record_fifo #(
    parameter int WIDTH = 42,
    parameter int DEPTH = 2
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     i_push,
    input  wire logic [WIDTH-1:0]         i_wdata,
    input  wire logic                     i_pop,
    output logic      [WIDTH-1:0]         o_rdata,
    output logic                          o_full,
    output logic                          o_empty,
    output logic      [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Storage write; contents need no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally (power-of-two depth); count tracks occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/alu_trace_sequencer.sv
`default_nettype none
// ============================================================================
//  Module  : alu_trace_sequencer
//  Purpose : Holds the ALU CPU in reset after system reset, issues credit-
//            limited next-instruction requests, buffers completed records and
//            serialises each as seven tagged bytes on a valid/ready stream.
//  Rev     : 1.0  initial release
// ============================================================================
module alu_trace_sequencer
    import alu_trace_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int CPU_RST_HOLD = 4
) (
    input  wire logic            clk,
    input  wire logic            rst,
    alu_trace_sequencer_if.slave bus,
    output logic                 cpu_rst,
    output logic                 cpu_next,
    output logic [7:0]           overflow_cnt
);
    localparam int         CW          = $clog2(DEPTH) + 1;
    localparam logic [3:0] c_hold_init = 4'(CPU_RST_HOLD);
    localparam logic [CW:0] c_depth_ext = (CW + 1)'(DEPTH);

    logic [3:0]       r_hold;
    logic             r_cpu_rst;
    logic             r_cpu_next;
    logic             r_outstanding;
    logic [7:0]       r_ovf;
    emit_state_t      r_state;
    trace_rec_t       r_shadow;
    logic [2:0]       r_idx;
    logic [7:0]       r_out_data;
    logic             r_out_valid;
    logic             r_out_last;

    trace_rec_t       w_wr_rec;
    trace_rec_t       w_rd_rec;
    logic [REC_W-1:0] w_rd_data;
    logic             w_full;
    logic             w_empty;
    logic [CW-1:0]    w_count;
    logic             w_rec_take;
    logic             w_pop;
    logic             w_drop;
    logic [CW:0]      w_credit_sum;
    logic             w_credit_ok;

    assign w_wr_rec = '{opcode: bus.rec_opcode, a: bus.rec_a, b: bus.rec_b,
                        result: bus.rec_result, carry: bus.rec_carry,
                        borrow: bus.rec_borrow, pc: bus.rec_pc};
    assign w_rd_rec = trace_rec_t'(w_rd_data);

    // Records arriving while the CPU is still held in reset are ignored
    assign w_rec_take = bus.rec_valid && !r_cpu_rst;

    // The FIFO is popped whenever the emitter moves into LOAD
    assign w_pop = !w_empty &&
                   ((r_state == ST_IDLE) ||
                    (r_state == ST_SEND && bus.out_ready && r_idx == TAG_PC));
    assign w_drop = w_rec_take && w_full && !w_pop;

    assign w_credit_sum = {1'b0, w_count} + {{CW{1'b0}}, r_outstanding};
    assign w_credit_ok  = (w_credit_sum < c_depth_ext);

    trace_record_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_rec_take),
        .i_wdata (w_wr_rec),
        .i_pop   (w_pop),
        .o_rdata (w_rd_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // CPU reset hold: stays asserted for CPU_RST_HOLD cycles after rst falls
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold    <= c_hold_init;
            r_cpu_rst <= 1'b1;
        end else begin
            r_cpu_rst <= (r_hold != 4'd0);
            if (r_hold != 4'd0) r_hold <= r_hold - 4'd1;
        end
    end

    // Single-credit request: one cpu_next per returned record, FIFO-space limited
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cpu_next    <= 1'b0;
            r_outstanding <= 1'b0;
        end else if (!r_cpu_rst && !r_outstanding && w_credit_ok) begin
            r_cpu_next    <= 1'b1;
            r_outstanding <= 1'b1;
        end else begin
            r_cpu_next <= 1'b0;
            if (w_rec_take) r_outstanding <= 1'b0;
        end
    end

    // Saturating count of records lost to a full FIFO
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 8'h00;
        end else if (w_drop && r_ovf != 8'hFF) begin
            r_ovf <= r_ovf + 8'h01;
        end
    end

    // Emit FSM: pop into shadow, then walk the seven fields under valid/ready
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_shadow    <= '0;
            r_idx       <= TAG_OPCODE;
            r_out_data  <= 8'h00;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_shadow <= w_rd_rec;
                        r_state  <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_state     <= ST_SEND;
                    r_idx       <= TAG_OPCODE;
                    r_out_data  <= rec_field(r_shadow, TAG_OPCODE);
                    r_out_valid <= 1'b1;
                    r_out_last  <= 1'b0;
                end
                ST_SEND: begin
                    if (bus.out_ready) begin
                        if (r_idx == TAG_PC) begin
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            if (!w_empty) begin
                                r_shadow <= w_rd_rec;
                                r_state  <= ST_LOAD;
                            end else begin
                                r_state  <= ST_IDLE;
                            end
                        end else begin
                            r_idx      <= r_idx + 3'd1;
                            r_out_data <= rec_field(r_shadow, r_idx + 3'd1);
                            r_out_last <= ((r_idx + 3'd1) == TAG_PC);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cpu_rst       = r_cpu_rst;
    assign cpu_next      = r_cpu_next;
    assign overflow_cnt  = r_ovf;
    assign bus.out_data  = r_out_data;
    assign bus.out_type  = r_idx;
    assign bus.out_valid = r_out_valid;
    assign bus.out_last  = r_out_last;
endmodule
`default_nettype wire

// File: tb/tb_alu_trace_sequencer.sv
`default_nettype none
// ============================================================================
//  Module  : tb_alu_trace_sequencer
//  Purpose : Scoreboard bench for alu_trace_sequencer: directed records push
//            expected bytes, a negedge monitor pops and compares stream bytes.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_alu_trace_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cpu_rst;
    logic       cpu_next;
    logic [7:0] ovf;

    alu_trace_sequencer_if bus();

    alu_trace_sequencer #(.DEPTH(2), .CPU_RST_HOLD(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .cpu_rst      (cpu_rst),
        .cpu_next     (cpu_next),
        .overflow_cnt (ovf)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [11:0] exp_q[$];     // {last, type, data}

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push_rec(input logic [7:0] op, a, b, res, input logic c, bo, input logic [7:0] pc);
        exp_q.push_back({1'b0, 3'd0, op});
        exp_q.push_back({1'b0, 3'd1, a});
        exp_q.push_back({1'b0, 3'd2, b});
        exp_q.push_back({1'b0, 3'd3, res});
        exp_q.push_back({1'b0, 3'd4, 7'b0, c});
        exp_q.push_back({1'b0, 3'd5, 7'b0, bo});
        exp_q.push_back({1'b1, 3'd6, pc});
    endtask

    task automatic set_rec(input logic [7:0] op, a, b, res, input logic c, bo, input logic [7:0] pc);
        bus.rec_opcode = op; bus.rec_a = a; bus.rec_b = b; bus.rec_result = res;
        bus.rec_carry = c; bus.rec_borrow = bo; bus.rec_pc = pc;
    endtask

    // One-cycle record strobe, captured on the second posedge of the task
    task automatic drive_rec(input logic [7:0] op, a, b, res, input logic c, bo, input logic [7:0] pc);
        @(posedge clk); #1;
        push_rec(op, a, b, res, c, bo, pc);
        set_rec(op, a, b, res, c, bo, pc);
        bus.rec_valid = 1'b1;
        @(posedge clk); #1;
        bus.rec_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(name, {31'b0, n < 300}, 32'd1);
        repeat (2) @(posedge clk);
    endtask

    task automatic reset_seq();
        @(posedge clk); #1;
        rst = 1'b1;
        bus.rec_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cpu_rst",   {31'b0, cpu_rst},       32'd1);
        chk("rst_cpu_next",  {31'b0, cpu_next},      32'd0);
        chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst_out_fields", {20'b0, bus.out_last, bus.out_type, bus.out_data}, 32'd0);
        chk("rst_overflow",  {24'b0, ovf},           32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        // Records offered while the CPU is held must be ignored
        set_rec(8'hEE, 8'hEE, 8'hEE, 8'hEE, 1'b1, 1'b1, 8'hEE);
        bus.rec_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("hold_cpu_rst",  {31'b0, cpu_rst},  32'd1);
            chk("hold_cpu_next", {31'b0, cpu_next}, 32'd0);
            if (k == 2) bus.rec_valid = 1'b0;
        end
        @(posedge clk); @(negedge clk);
        chk("release_cpu_rst",  {31'b0, cpu_rst},  32'd0);
        chk("release_cpu_next", {31'b0, cpu_next}, 32'd0);
        @(posedge clk); @(negedge clk);
        chk("first_cpu_next", {31'b0, cpu_next}, 32'd1);
        @(posedge clk); @(negedge clk);
        chk("cpu_next_single", {31'b0, cpu_next}, 32'd0);
    endtask

    // Monitor: compare each accepted byte and check stability during stalls
    logic        hold_v = 1'b0;
    logic [11:0] hold_b = '0;
    always @(negedge clk) begin
        logic [11:0] cur;
        logic [11:0] e;
        cur = {bus.out_last, bus.out_type, bus.out_data};
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) chk("stall_hold", {19'b0, bus.out_valid, cur}, {19'b0, 1'b1, hold_b});
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte actual=%0h required=none", cur);
                end else begin
                    e = exp_q.pop_front();
                    chk("stream_byte", {20'b0, cur}, {20'b0, e});
                end
            end
            hold_v = bus.out_valid && !bus.out_ready;
            hold_b = cur;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  lat, cyc, acc, n, grants;
        bit  found;
        bus.rec_valid = 1'b0;
        set_rec(8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
        bus.out_ready = 1'b1;

        reset_seq();

        // Single record with latency measurement
        drive_rec(8'h21, 8'hFB, 8'h03, 8'hFE, 1'b0, 1'b1, 8'h07);
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); @(negedge clk);
            if (bus.out_valid) begin
                lat = i;
                break;
            end
        end
        chk("first_valid_latency", lat, 32'd2);
        wait_drain("single_drain");

        // Two back-to-back records: 14 bytes over 15 cycles (one bubble)
        cyc = 0; acc = 0; n = 0;
        fork
            begin
                drive_rec(8'h01, 8'h02, 8'h03, 8'h04, 1'b1, 1'b0, 8'h10);
                drive_rec(8'h81, 8'h7F, 8'h80, 8'hFF, 1'b1, 1'b1, 8'h11);
            end
            begin
                while (!bus.out_valid && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                while (acc < 14 && cyc < 60) begin
                    if (bus.out_valid && bus.out_ready) acc++;
                    cyc++;
                    @(negedge clk);
                end
            end
        join
        chk("throughput_cycles", cyc, 32'd15);
        wait_drain("throughput_drain");

        // Back-pressure at tag 2
        drive_rec(8'h3C, 8'h11, 8'h03, 8'h14, 1'b0, 1'b0, 8'h08);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.out_valid && bus.out_type == 3'd1) && n < 30);
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_tag2", {20'b0, bus.out_valid, bus.out_type, bus.out_data},
                {20'b0, 1'b1, 3'd2, 8'h03});
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        wait_drain("bp_drain");

        // Overflow: one record stalled in shadow, then three forced records
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        drive_rec(8'h55, 8'hAA, 8'h0F, 8'hF0, 1'b0, 1'b0, 8'h20);
        repeat (4) @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            set_rec(8'(64 + i), 8'(16 + i), 8'(32 + i), 8'(48 + i), i[0], 1'b0, 8'(80 + i));
            if (i < 2) push_rec(8'(64 + i), 8'(16 + i), 8'(32 + i), 8'(48 + i), i[0], 1'b0, 8'(80 + i));
            bus.rec_valid = 1'b1;
        end
        @(posedge clk); #1;
        bus.rec_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("overflow_cnt", {24'b0, ovf}, 32'd1);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        wait_drain("overflow_drain");

        // Credit: with the stream stalled only two further requests are granted
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        drive_rec(8'hC0, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 8'h30);
        grants = 0;
        while (grants < 5) begin
            found = 1'b0;
            n = 0;
            while (n < 12 && !found) begin
                @(negedge clk);
                n++;
                if (cpu_next) found = 1'b1;
            end
            if (!found) break;
            grants++;
            drive_rec(8'(8'hC0 + grants), 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 8'(8'h30 + grants));
        end
        chk("credit_grants", grants, 32'd2);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        found = 1'b0;
        n = 0;
        while (n < 30 && !found) begin
            @(negedge clk);
            n++;
            if (cpu_next) found = 1'b1;
        end
        chk("credit_resume", {31'b0, found}, 32'd1);
        if (found) drive_rec(8'hC3, 8'h01, 8'h01, 8'h02, 1'b1, 1'b0, 8'h33);
        wait_drain("credit_drain");

        // Reset in the middle of a record (tag 4 on the bus)
        drive_rec(8'h99, 8'h12, 8'h34, 8'h56, 1'b1, 1'b0, 8'h60);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.out_valid && bus.out_type == 3'd3) && n < 30);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("midrst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("midrst_overflow",  {24'b0, ovf},           32'd0);
        exp_q.delete();
        reset_seq();
        repeat (10) @(posedge clk);
        chk("final_queue_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
